jvm_arm_translator: RTL

Parametrised bytecode-to-ARM translation engine for the JIT path. It consumes a JVM bytecode byte stream through a valid/ready handshake and handles the `wide` prefix. It assembles 8- or 16-bit operands and pushes each one to the operand stack interface. It then walks a linked template ROM and emits ARM instruction words through a valid/ready output, with all ROMs external and combinational.

---
 rtl/jvm_arm_translator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jvm_arm_translator.sv
// JVM bytecode to ARM template translator: fetches opcode/operands, pushes operands, walks a linked template ROM.
// Optional build macro JAT_OPERAND_PATCH_EN patches the imm12 field of flagged template words with the last operand.
module jvm_arm_translator #(
   parameter int          DATA_W      = 32,
   parameter int          ROM_ADDR_W  = 10,
   parameter int          OPERAND_W   = 16,
   parameter int          PCNT_W      = 3,
   parameter logic [7:0]  WIDE_OPCODE = 8'hC4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bc_valid,
   input  logic [7:0]            bc_data,
   output logic                  bc_ready,
   output logic [7:0]            lut_opcode,
   input  logic [PCNT_W-1:0]     lut_nparams,
   input  logic [ROM_ADDR_W-1:0] lut_tmpl_addr,
   output logic [ROM_ADDR_W-1:0] tmpl_addr,
   input  logic [DATA_W-1:0]     tmpl_word,
   input  logic [ROM_ADDR_W-1:0] tmpl_next,
   input  logic                  tmpl_patch,
   output logic                  opnd_valid,
   output logic [OPERAND_W-1:0]  opnd_data,
   input  logic                  opnd_ready,
   output logic                  arm_valid,
   output logic [DATA_W-1:0]     arm_word,
   input  logic                  arm_ready,
   output logic                  insn_done,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_FETCH_OP, S_DECODE, S_FETCH_PARAM, S_PUSH, S_EMIT_LOAD, S_EMIT_HOLD, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  wide_q, wide_d;
   logic                  phase_q, phase_d;
   logic [PCNT_W-1:0]     count_q, count_d;
   logic [ROM_ADDR_W-1:0] cur_q, cur_d;
   logic [ROM_ADDR_W-1:0] nxt_q, nxt_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            lut_opcode_q, lut_opcode_d;
   logic [OPERAND_W-1:0]  opnd_data_q, opnd_data_d;
   logic [DATA_W-1:0]     arm_word_q, arm_word_d;
   logic [DATA_W-1:0]     emit_word;

`ifdef JAT_OPERAND_PATCH_EN
   logic [11:0] last_opnd_q, last_opnd_d;

   always_comb begin
      emit_word = tmpl_word;
      if (tmpl_patch) emit_word[11:0] = last_opnd_q;
   end

   always_comb begin
      last_opnd_d = last_opnd_q;
      if (state_q == S_PUSH && opnd_ready) last_opnd_d = opnd_data_q[11:0];
      else if (state_q == S_DONE)         last_opnd_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_opnd_q <= '0;
      else        last_opnd_q <= last_opnd_d;
   end
`else
   logic unused_patch;
   assign unused_patch = tmpl_patch;
   assign emit_word    = tmpl_word;
`endif

   always_comb begin
      state_d      = state_q;
      wide_d       = wide_q;
      phase_d      = phase_q;
      count_d      = count_q;
      cur_d        = cur_q;
      nxt_d        = nxt_q;
      hi_d         = hi_q;
      lut_opcode_d = lut_opcode_q;
      opnd_data_d  = opnd_data_q;
      arm_word_d   = arm_word_q;
      case (state_q)
         S_FETCH_OP: begin
            if (bc_valid) begin
               lut_opcode_d = bc_data;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            if (lut_opcode_q == WIDE_OPCODE) begin
               wide_d  = 1'b1;
               state_d = S_FETCH_OP;
            end else begin
               count_d = lut_nparams;
               cur_d   = lut_tmpl_addr;
               if (lut_nparams != '0)        state_d = S_FETCH_PARAM;
               else if (lut_tmpl_addr != '0) state_d = S_EMIT_LOAD;
               else                          state_d = S_DONE;
            end
         end
         S_FETCH_PARAM: begin
            if (bc_valid) begin
               if (!wide_q) begin
                  opnd_data_d = OPERAND_W'(bc_data);
                  state_d     = S_PUSH;
               end else if (!phase_q) begin
                  hi_d    = bc_data;
                  phase_d = 1'b1;
               end else begin
                  // wide operands arrive big-endian
                  opnd_data_d = OPERAND_W'({hi_q, bc_data});
                  phase_d     = 1'b0;
                  state_d     = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            if (opnd_ready) begin
               count_d = count_q - PCNT_W'(1);
               if (count_q == PCNT_W'(1)) state_d = (cur_q != '0) ? S_EMIT_LOAD : S_DONE;
               else                       state_d = S_FETCH_PARAM;
            end
         end
         S_EMIT_LOAD: begin
            arm_word_d = emit_word;
            nxt_d      = tmpl_next;
            state_d    = S_EMIT_HOLD;
         end
         S_EMIT_HOLD: begin
            if (arm_ready) begin
               if (nxt_q == '0) state_d = S_DONE;
               else begin
                  cur_d   = nxt_q;
                  state_d = S_EMIT_LOAD;
               end
            end
         end
         S_DONE: begin
            wide_d  = 1'b0;
            phase_d = 1'b0;
            state_d = S_FETCH_OP;
         end
         default: state_d = S_FETCH_OP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH_OP;
         wide_q       <= 1'b0;
         phase_q      <= 1'b0;
         count_q      <= '0;
         cur_q        <= '0;
         nxt_q        <= '0;
         hi_q         <= '0;
         lut_opcode_q <= '0;
         opnd_data_q  <= '0;
         arm_word_q   <= '0;
      end else begin
         state_q      <= state_d;
         wide_q       <= wide_d;
         phase_q      <= phase_d;
         count_q      <= count_d;
         cur_q        <= cur_d;
         nxt_q        <= nxt_d;
         hi_q         <= hi_d;
         lut_opcode_q <= lut_opcode_d;
         opnd_data_q  <= opnd_data_d;
         arm_word_q   <= arm_word_d;
      end
   end

   // cur_q doubles as the template ROM address register
   assign tmpl_addr  = cur_q;
   assign lut_opcode = lut_opcode_q;
   assign opnd_data  = opnd_data_q;
   assign arm_word   = arm_word_q;
   assign bc_ready   = (state_q == S_FETCH_OP) || (state_q == S_FETCH_PARAM);
   assign opnd_valid = (state_q == S_PUSH);
   assign arm_valid  = (state_q == S_EMIT_HOLD);
   assign insn_done  = (state_q == S_DONE);
   assign busy       = (state_q != S_FETCH_OP);

endmodule
